// File: rtl/motores_alternados.sv
// Two-motor alternator: START/STOP/soft-RESET buttons, test-mode period switch and fault latch.
// Optional fault handling (I5, FAULT state, O5) is enabled by defining MOTORES_ALTERNADOS_FAULT_EN.
module motores_alternados #(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned T_NORMAL_S   = 5,
   parameter int unsigned T_TEST_S     = 2,
   parameter int unsigned DB_MS_BTN    = 20,
   parameter int unsigned DB_MS_TESTLV = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic I1,
   input  logic I2,
   input  logic I3,
   input  logic I4,
   input  logic I5,
   output logic O1,
   output logic O2,
   output logic O3,
   output logic O4,
   output logic O5
);

   localparam int unsigned N_BTN  = CLK_HZ / 1000 * DB_MS_BTN;
   localparam int unsigned N_TST  = CLK_HZ / 1000 * DB_MS_TESTLV;
   localparam int unsigned N_MAX  = (N_BTN > N_TST) ? N_BTN : N_TST;
   localparam int unsigned CW     = (N_MAX > 2) ? $clog2(N_MAX) : 1;
   localparam int unsigned P_NORM = CLK_HZ * T_NORMAL_S;
   localparam int unsigned P_TEST = CLK_HZ * T_TEST_S;
   localparam int unsigned P_MAX  = (P_NORM > P_TEST) ? P_NORM : P_TEST;
   localparam int unsigned TW     = (P_MAX > 2) ? $clog2(P_MAX) : 1;

   localparam logic [CW-1:0] LIM_BTN = CW'(N_BTN - 1);
   localparam logic [CW-1:0] LIM_TST = CW'(N_TST - 1);
   localparam logic [TW-1:0] END_NORM = TW'(P_NORM - 1);
   localparam logic [TW-1:0] END_TEST = TW'(P_TEST - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN_M1 = 2'd1,
      RUN_M2 = 2'd2
`ifdef MOTORES_ALTERNADOS_FAULT_EN
      ,
      FAULT  = 2'd3
`endif
   } state_t;

   // Channel order in the vectors below: [0]=I1 START, [1]=I2 STOP, [2]=I3 RESET, [3]=I4 test level.
   logic [3:0]         sync1_q, sync2_q;
   logic [3:0]         stable_q, stable_d;
   logic [3:0]         prev_q;
   logic [2:0]         pulse_q;
   logic [3:0][CW-1:0] cnt_q, cnt_d;
   state_t             state_q, state_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [TW-1:0]      timer_end;
   logic               mode_chg;
   logic               fault_s;

`ifdef MOTORES_ALTERNADOS_FAULT_EN
   logic f1_q, f2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f1_q <= 1'b0;
         f2_q <= 1'b0;
      end else begin
         f1_q <= I5;
         f2_q <= f1_q;
      end
   end

   assign fault_s = f2_q;
`else
   logic unused_i5;
   assign unused_i5 = I5;
   assign fault_s   = 1'b0;
`endif

   // A mismatching sample advances the count; a matching sample clears it.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == ((i == 3) ? LIM_TST : LIM_BTN)) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign mode_chg  = stable_q[3] ^ prev_q[3];
   assign timer_end = stable_q[3] ? END_TEST : END_NORM;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      if (fault_s) begin
`ifdef MOTORES_ALTERNADOS_FAULT_EN
         state_d = FAULT;
`endif
         timer_d = '0;
      end else if (pulse_q[2]) begin
         state_d = IDLE;
         timer_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pulse_q[0]) begin
                  state_d = RUN_M1;
                  timer_d = '0;
               end
            end
            RUN_M1, RUN_M2: begin
               if (pulse_q[1]) begin
                  state_d = IDLE;
                  timer_d = '0;
               end else if (mode_chg) begin
                  timer_d = '0;
               end else if (timer_q >= timer_end) begin
                  state_d = (state_q == RUN_M1) ? RUN_M2 : RUN_M1;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            default: begin
               // FAULT is left only through the RESET branch above.
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         prev_q   <= '0;
         pulse_q  <= '0;
         cnt_q    <= '0;
         state_q  <= IDLE;
         timer_q  <= '0;
         O1       <= 1'b0;
         O2       <= 1'b0;
         O3       <= 1'b0;
         O4       <= 1'b0;
      end else begin
         sync1_q  <= {I4, I3, I2, I1};
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         prev_q   <= stable_q;
         pulse_q  <= stable_q[2:0] & ~prev_q[2:0];
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         timer_q  <= timer_d;
         O1       <= (state_q == RUN_M1);
         O2       <= (state_q == RUN_M2);
         O3       <= (state_q == RUN_M1) || (state_q == RUN_M2);
         O4       <= prev_q[3];
      end
   end

`ifdef MOTORES_ALTERNADOS_FAULT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         O5 <= 1'b0;
      end else begin
         O5 <= (state_q == FAULT);
      end
   end
`else
   assign O5 = 1'b0;
`endif

endmodule

// File: tb/tb_motores_alternados.sv
// Directed bench for motores_alternados with shortened timing (N=20, normal period 5000, test period 2000).
module tb_motores_alternados;

   localparam int N_DB = 20;
   localparam int P_N  = 5000;
   localparam int P_T  = 2000;

   logic clk = 1'b0;
   logic rst;
   logic I1, I2, I3, I4, I5;
   logic O1, O2, O3, O4, O5;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   motores_alternados #(
      .CLK_HZ      (1000),
      .T_NORMAL_S  (5),
      .T_TEST_S    (2),
      .DB_MS_BTN   (20),
      .DB_MS_TESTLV(20)
   ) dut (
      .clk(clk), .rst(rst),
      .I1(I1), .I2(I2), .I3(I3), .I4(I4), .I5(I5),
      .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
   endtask

   // Contactors must never both be closed.
   always @(negedge clk) if (rst === 1'b0) chk("mutex", {7'd0, O1 & O2}, 8'd0);

   // Returns at the falling edge that follows rising edge number j.
   task automatic at_edge(input int j);
      do @(negedge clk); while (cyc < j);
   endtask

   task automatic set_in(input int which, input logic v);
      case (which)
         1: I1 = v;
         2: I2 = v;
         3: I3 = v;
         4: I4 = v;
         default: I5 = v;
      endcase
   endtask

   // Raises an input after edge t; k is the first edge that samples it.
   task automatic press_at(input int which, input int t, output int k);
      at_edge(t);
      set_in(which, 1'b1);
      k = t + 1;
   endtask

   task automatic do_start(input int t, output int e);
      int k;
      press_at(1, t, k);
      at_edge(k + N_DB + 3);
      chk("start_pre", {5'd0, O1, O2, O3}, 8'b000);
      at_edge(k + N_DB + 4);
      chk("start_on", {5'd0, O1, O2, O3}, 8'b101);
      e = k + N_DB + 4;
      at_edge(e + 30);
      I1 = 1'b0;
   endtask

   initial begin
      int e, k, c, g, h, j;
      rst = 1'b1;
      {I1, I2, I3, I4, I5} = '0;
      repeat (3) @(negedge clk);
      chk("rst_hold", {3'd0, O1, O2, O3, O4, O5}, 8'd0);
      rst = 1'b0;
      at_edge(cyc + 500);
      chk("idle_500", {3'd0, O1, O2, O3, O4, O5}, 8'd0);
      at_edge(cyc + 500);
      chk("idle_1000", {3'd0, O1, O2, O3, O4, O5}, 8'd0);

      // Glitch shorter than the debounce window
      press_at(1, cyc + 5, k);
      at_edge(k + 9);
      I1 = 1'b0;
      at_edge(k + 200);
      chk("glitch", {3'd0, O1, O2, O3, O4, O5}, 8'd0);

      // Start and normal alternation
      do_start(cyc + 5, e);
      at_edge(e + P_N - 1);
      chk("norm_m1_end", {5'd0, O1, O2, O3}, 8'b101);
      at_edge(e + P_N);
      chk("norm_to_m2", {5'd0, O1, O2, O3}, 8'b011);
      at_edge(e + 2 * P_N - 1);
      chk("norm_m2_end", {5'd0, O1, O2, O3}, 8'b011);
      at_edge(e + 2 * P_N);
      chk("norm_to_m1", {5'd0, O1, O2, O3}, 8'b101);
      g = e + 2 * P_N;

      // Test mode: O4 latency and timer restart keeping motor 1
      press_at(4, g + 100, k);
      at_edge(k + N_DB + 2);
      chk("o4_pre", {7'd0, O4}, 8'd0);
      at_edge(k + N_DB + 3);
      chk("o4_on", {7'd0, O4}, 8'd1);
      c = k + N_DB + 2;
      at_edge(c + P_T);
      chk("test_m1_end", {5'd0, O1, O2, O3}, 8'b101);
      at_edge(c + P_T + 1);
      chk("test_to_m2", {5'd0, O1, O2, O3}, 8'b011);
      at_edge(c + 2 * P_T + 1);
      chk("test_to_m1", {5'd0, O1, O2, O3}, 8'b101);
      g = c + 2 * P_T + 1;

      // Back to normal mode
      at_edge(g + 50);
      I4 = 1'b0;
      k = g + 51;
      at_edge(k + N_DB + 2);
      chk("o4_hold", {7'd0, O4}, 8'd1);
      at_edge(k + N_DB + 3);
      chk("o4_off", {7'd0, O4}, 8'd0);
      c = k + N_DB + 2;
      at_edge(c + P_N);
      chk("back_m1_end", {5'd0, O1, O2, O3}, 8'b101);
      at_edge(c + P_N + 1);
      chk("back_to_m2", {5'd0, O1, O2, O3}, 8'b011);
      h = c + P_N + 1;

      // STOP, then restart
      press_at(2, h + 10, k);
      at_edge(k + N_DB + 3);
      chk("stop_pre", {5'd0, O1, O2, O3}, 8'b011);
      at_edge(k + N_DB + 4);
      chk("stop_off", {5'd0, O1, O2, O3}, 8'b000);
      at_edge(k + N_DB + 30);
      I2 = 1'b0;
      do_start(k + N_DB + 60, e);

      // Soft RESET while running
      press_at(3, e + 100, k);
      at_edge(k + N_DB + 3);
      chk("sreset_pre", {5'd0, O1, O2, O3}, 8'b101);
      at_edge(k + N_DB + 4);
      chk("sreset_off", {5'd0, O1, O2, O3}, 8'b000);
      at_edge(k + N_DB + 30);
      I3 = 1'b0;
      do_start(k + N_DB + 60, e);

`ifdef MOTORES_ALTERNADOS_FAULT_EN
      j = e + 50;
      at_edge(j);
      I5 = 1'b1;
      at_edge(j + 4);
      chk("fault_on", {4'd0, O1, O2, O3, O5}, 8'b0001);
      press_at(1, j + 10, k);
      at_edge(j + 60);
      I1 = 1'b0;
      at_edge(j + 70);
      chk("fault_ign_start", {4'd0, O1, O2, O3, O5}, 8'b0001);
      press_at(2, j + 80, k);
      at_edge(j + 130);
      I2 = 1'b0;
      at_edge(j + 140);
      chk("fault_ign_stop", {4'd0, O1, O2, O3, O5}, 8'b0001);
      press_at(3, j + 150, k);
      at_edge(j + 200);
      I3 = 1'b0;
      at_edge(j + 210);
      chk("fault_rst_blocked", {4'd0, O1, O2, O3, O5}, 8'b0001);
      at_edge(j + 220);
      I5 = 1'b0;
      at_edge(j + 240);
      chk("fault_latched", {4'd0, O1, O2, O3, O5}, 8'b0001);
      press_at(3, j + 250, k);
      at_edge(k + N_DB + 3);
      chk("fault_clr_pre", {4'd0, O1, O2, O3, O5}, 8'b0001);
      at_edge(k + N_DB + 4);
      chk("fault_clr", {4'd0, O1, O2, O3, O5}, 8'b0000);
      at_edge(k + N_DB + 30);
      I3 = 1'b0;
      do_start(k + N_DB + 60, e);
`else
      j = e + 50;
      at_edge(j);
      I5 = 1'b1;
      at_edge(j + 50);
      chk("i5_ignored", {4'd0, O1, O2, O3, O5}, 8'b1010);
      I5 = 1'b0;
`endif

      // Asynchronous reset drops motors before the next clock edge
      at_edge(e + 100);
      rst = 1'b1;
      #1;
      chk("async_rst", {3'd0, O1, O2, O3, O4, O5}, 8'd0);
      at_edge(cyc + 3);
      chk("rst_held", {3'd0, O1, O2, O3, O4, O5}, 8'd0);
      rst = 1'b0;
      at_edge(cyc + 5);
      chk("post_rst", {3'd0, O1, O2, O3, O4, O5}, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/motores_alternados.md
MOTORES_ALTERNADOS -- requirements
Module: motores_alternados

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000; clock frequency in Hz.
REQ-002 SHALL have parameter T_NORMAL_S, default 5; alternation period in normal mode, in seconds.
REQ-003 SHALL have parameter T_TEST_S, default 2; alternation period in test mode, in seconds.
REQ-004 SHALL have parameter DB_MS_BTN, default 20; debounce window for I1/I2/I3, in ms.
REQ-005 SHALL have parameter DB_MS_TESTLV, default 20; debounce window for I4, in ms.
REQ-006 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-008 SHALL have port I1, input, 1 bit; START push-button, active high.
REQ-009 SHALL have port I2, input, 1 bit; STOP push-button, active high.
REQ-010 SHALL have port I3, input, 1 bit; soft-RESET push-button, active high.
REQ-011 SHALL have port I4, input, 1 bit; test-mode level, 1 = test mode.
REQ-012 SHALL have port I5, input, 1 bit; motor fault/overload, active high.
REQ-013 SHALL have ports O1 and O2, output, 1 bit each; motor 1 and motor 2 contactors.
REQ-014 SHALL have ports O3, O4 and O5, output, 1 bit each; running lamp, test-mode lamp and fault lamp.

Function
REQ-015 Each of I1..I5 SHALL pass through a 2-FF synchronizer.
REQ-016 Debounce for I1..I4: the stable level SHALL change only after the synchronized input differs from it for N consecutive cycles.
- N = CLK_HZ/1000*DB_MS_BTN for I1/I2/I3.
- N = CLK_HZ/1000*DB_MS_TESTLV for I4.
- The count SHALL clear on any sample equal to the stable level.
REQ-017 START, STOP and RESET SHALL act on a one-cycle registered rising-edge pulse of the debounced level.
REQ-018 FSM states SHALL be IDLE, RUN_M1, RUN_M2 and FAULT.
REQ-019 Outputs by state (all outputs registered):
- IDLE: O1=O2=O3=0.
- RUN_M1: O1=1, O2=0, O3=1.
- RUN_M2: O1=0, O2=1, O3=1.
- FAULT: O1=O2=O3=0, O5=1; O5=0 in every other state.
REQ-020 START in IDLE SHALL enter RUN_M1 with the period timer cleared; START while running SHALL be ignored.
REQ-021 The period timer SHALL count cycles while in RUN_M1/RUN_M2.
- On reaching P-1 it SHALL toggle RUN_M1<->RUN_M2 and clear.
- P = CLK_HZ*T_TEST_S when debounced I4=1, else CLK_HZ*T_NORMAL_S.
REQ-022 Timer width SHALL hold the larger P without overflow.
REQ-023 Any change of debounced I4 SHALL clear the timer and keep the current motor.
REQ-024 STOP while running SHALL go to IDLE.
REQ-025 RESET (I3 pulse) from any state SHALL go to IDLE with the timer cleared, except FAULT while synchronized I5=1.
REQ-026 Synchronized I5=1 SHALL force FAULT from any state, without debounce.
REQ-027 FAULT SHALL be left only by a RESET pulse with I5=0; START and STOP SHALL be ignored in FAULT.
REQ-028 Simultaneous events SHALL follow the priority fault > RESET > STOP > START > timer expiry.
REQ-029 Latency from the first clock sampling I1 high (held >= window) to O1=1 SHALL be N+4 cycles.
REQ-030 O4 SHALL equal debounced I4 through one register, i.e. N+3 cycles after an I4 change, independent of state.
REQ-031 O1 and O2 SHALL never be 1 in the same cycle.

Reset
REQ-032 rst=1 SHALL asynchronously set state IDLE and clear the timer, debounce counters, stable levels, synchronizers and edge registers.
REQ-033 During rst=1 all outputs O1..O5 SHALL be 0.
REQ-034 Release of rst SHALL be synchronous to clk; the first state change is possible on the first rising edge after release.
REQ-035 rst asserted mid-run SHALL drop both motors within the same cycle (asynchronous).

Configuration
REQ-036 Macro MOTORES_ALTERNADOS_FAULT_EN:
- Defined: I5 and the FAULT state SHALL behave per REQ-026..REQ-028.
- Undefined: I5 SHALL be ignored, the FAULT state absent, and O5 tied to 0.

Verification
(CLK_HZ=100_000, T_NORMAL_S=5, T_TEST_S=2, DB_MS_BTN=DB_MS_TESTLV=2, so N=200 cycles.)
REQ-037 Pulse rst, all inputs 0 -> O1..O5=0 for 1000 cycles.
REQ-038 I1=1 for 500 cycles -> O1=O3=1 exactly 204 cycles after I1 rise; O1->O2 after a further 500_000 cycles, back to O1 after 500_000 more.
REQ-039 I1 glitch of 100 cycles -> no start, outputs stay 0.
REQ-040 While running set I4=1 -> O4=1 after 203 cycles; motor toggles every 200_000 cycles. Then set I4=0 -> toggles every 500_000 cycles.
REQ-041 I2 held 500 cycles while running -> O1=O2=O3=0. Then I1 again -> RUN_M1.
REQ-042 Fault-path checks, both with macro defined:
- I5=1 while running -> O5=1 and motors off within 3 cycles; I1/I2 pulses ignored.
- I5=0 then I3 pulse -> IDLE, O5=0.
- I3 pulse while running -> IDLE.
